// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: WIDTH cycles from accept to out_valid,
// optional two's-complement input, valid/ready handshake on both sides.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  sign_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_next;
  logic             carry;
  logic             is_neg;
  logic [WIDTH-1:0] mag_in;

  assign in_ready = (state == IDLE) && !rst;
  assign is_neg   = sign_en && bin[WIDTH-1];
  // Negating the most negative value wraps to 2^(WIDTH-1), which is exact as unsigned.
  assign mag_in   = is_neg ? -bin : bin;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    carry    = adj[BW-1];
    acc_next = {adj[BW-2:0], mag[WIDTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mag   <= mag_in;
            neg   <= is_neg;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          // A bit leaving the top digit means the magnitude exceeds DIGITS digits.
          if (carry) ovf <= 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bcd       <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
